// File: rtl/sb_shadow_cfg_param_pkg.sv
// rtl/sb_shadow_cfg_param_pkg.sv - shared types and elaboration helpers for the shadow-config switch block
package sb_cfg_pkg;

  typedef enum logic {
    CFG_EMPTY = 1'b0,
    CFG_LIVE  = 1'b1
  } cfg_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int cfg_bits(input int m, input int sel_w);
    return 2 * m * sel_w;
  endfunction

  function automatic bit params_ok(input int chan_w, input int m, input int mux_size);
    return (chan_w > m) && (m >= 1) && (mux_size >= 2);
  endfunction

endpackage

// File: rtl/sb_shadow_cfg_param_if.sv
// rtl/sb_shadow_cfg_param_if.sv - configuration-chain signal bundle
interface sb_shadow_cfg_param_if;

  logic ccff_head;
  logic ccff_en;
  logic cfg_commit;
  logic ccff_tail;
  logic cfg_valid;
  logic cfg_done;
  logic cfg_overflow;

  modport master (
    output ccff_head, ccff_en, cfg_commit,
    input  ccff_tail, cfg_valid, cfg_done, cfg_overflow
  );

  modport slave (
    input  ccff_head, ccff_en, cfg_commit,
    output ccff_tail, cfg_valid, cfg_done, cfg_overflow
  );

endinterface

// File: rtl/sb_shadow_cfg_param_chain.sv
// rtl/sb_shadow_cfg_param_chain.sv - shadow/active config registers, shift counter and commit state
module sb_cfg_chain
  import sb_cfg_pkg::*;
#(
  parameter int CFG_BITS = 8
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                ccff_head_i,
  input  logic                ccff_en_i,
  input  logic                cfg_commit_i,
  output logic                ccff_tail_o,
  output logic                cfg_valid_o,
  output logic                cfg_done_o,
  output logic                cfg_overflow_o,
  output logic [CFG_BITS-1:0] active_o
);

  localparam int CNT_W = clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  cfg_state_e          state_q, state_d;

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shadow_q   <= '0;
      active_q   <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= CFG_EMPTY;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      count_q    <= count_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  // Commit samples the pre-shift shadow, so a same-cycle shift is never lost or half-applied.
  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    state_d    = state_q;

    if (ccff_en_i) begin
      shadow_d = {shadow_q[CFG_BITS-2:0], ccff_head_i};
    end

    if (cfg_commit_i) begin
      active_d   = shadow_q;
      overflow_d = 1'b0;
      count_d    = ccff_en_i ? CNT_W'(1) : '0;
    end else if (ccff_en_i) begin
      if (count_q == CNT_FULL) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    case (state_q)
      CFG_EMPTY: if (cfg_commit_i) state_d = CFG_LIVE;
      CFG_LIVE:  state_d = CFG_LIVE;
      default:   state_d = CFG_EMPTY;
    endcase

    done_d = (count_d == CNT_FULL);
  end

  assign ccff_tail_o    = shadow_q[CFG_BITS-1];
  assign cfg_valid_o    = (state_q == CFG_LIVE);
  assign cfg_done_o     = done_q;
  assign cfg_overflow_o = overflow_q;
  assign active_o       = active_q;

endmodule

// File: rtl/sb_shadow_cfg_param.sv
// rtl/sb_shadow_cfg_param.sv - corner switch block with double-buffered configuration chain
module sb_shadow_cfg_param
  import sb_cfg_pkg::*;
#(
  parameter int CHAN_W   = 9,
  parameter int M        = 2,
  parameter int MUX_SIZE = 4
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  sb_shadow_cfg_param_if.slave  cfg,
  input  logic [CHAN_W-1:0]     chany_bottom_in,
  input  logic [CHAN_W-1:0]     chanx_left_in,
  input  logic [M*MUX_SIZE-1:0] bottom_mux_in,
  input  logic [M*MUX_SIZE-1:0] left_mux_in,
  output logic [CHAN_W-1:0]     chany_bottom_out,
  output logic [CHAN_W-1:0]     chanx_left_out
);

  localparam int SEL_W    = clog2(MUX_SIZE);
  localparam int CFG_BITS = cfg_bits(M, SEL_W);
  localparam logic [SEL_W:0] MUX_LIMIT = (SEL_W + 1)'(MUX_SIZE);

  if (!params_ok(CHAN_W, M, MUX_SIZE)) begin : g_param_check
    $error("sb_shadow_cfg_param: need CHAN_W > M, M >= 1, MUX_SIZE >= 2");
  end

  logic [CFG_BITS-1:0] active;
  logic                cfg_valid;
  logic [M-1:0]        bottom_mux_out;
  logic [M-1:0]        left_mux_out;
  logic                unused_tracks;

  sb_cfg_chain #(
    .CFG_BITS (CFG_BITS)
  ) u_chain (
    .prog_clk       (prog_clk),
    .prog_reset_n   (prog_reset_n),
    .ccff_head_i    (cfg.ccff_head),
    .ccff_en_i      (cfg.ccff_en),
    .cfg_commit_i   (cfg.cfg_commit),
    .ccff_tail_o    (cfg.ccff_tail),
    .cfg_valid_o    (cfg_valid),
    .cfg_done_o     (cfg.cfg_done),
    .cfg_overflow_o (cfg.cfg_overflow),
    .active_o       (active)
  );

  assign cfg.cfg_valid = cfg_valid;

  // Out-of-range selects (non-power-of-2 MUX_SIZE) and an uncommitted config both force 0.
  for (genvar j = 0; j < M; j++) begin : g_mux
    logic [SEL_W-1:0]    sel_b;
    logic [SEL_W-1:0]    sel_l;
    logic [MUX_SIZE-1:0] in_b;
    logic [MUX_SIZE-1:0] in_l;

    assign sel_b = active[j*SEL_W +: SEL_W];
    assign sel_l = active[(M+j)*SEL_W +: SEL_W];
    assign in_b  = bottom_mux_in[j*MUX_SIZE +: MUX_SIZE];
    assign in_l  = left_mux_in[j*MUX_SIZE +: MUX_SIZE];

    assign bottom_mux_out[j] = cfg_valid && ({1'b0, sel_b} < MUX_LIMIT) && in_b[sel_b];
    assign left_mux_out[j]   = cfg_valid && ({1'b0, sel_l} < MUX_LIMIT) && in_l[sel_l];
  end

  assign chany_bottom_out = {chanx_left_in[CHAN_W-1:M], bottom_mux_out};
  assign chanx_left_out   = {chany_bottom_in[CHAN_W-1:M], left_mux_out};

  assign unused_tracks = ^{chany_bottom_in[M-1:0], chanx_left_in[M-1:0]};

endmodule

// File: tb/tb_sb_shadow_cfg_param.sv
// tb/tb_sb_shadow_cfg_param.sv - self-checking bench for sb_shadow_cfg_param
module tb_sb_shadow_cfg_param;

  localparam int CHAN_W   = 9;
  localparam int M        = 2;
  localparam int MUX_SIZE = 4;
  localparam int SEL_W    = 2;
  localparam int CFG_BITS = 8;

  logic                  prog_clk = 1'b0;
  logic                  prog_reset_n;
  logic [CHAN_W-1:0]     chany_bottom_in;
  logic [CHAN_W-1:0]     chanx_left_in;
  logic [M*MUX_SIZE-1:0] bottom_mux_in;
  logic [M*MUX_SIZE-1:0] left_mux_in;
  logic [CHAN_W-1:0]     chany_bottom_out;
  logic [CHAN_W-1:0]     chanx_left_out;

  sb_shadow_cfg_param_if cfg_if ();

  sb_shadow_cfg_param #(
    .CHAN_W   (CHAN_W),
    .M        (M),
    .MUX_SIZE (MUX_SIZE)
  ) dut (
    .prog_clk         (prog_clk),
    .prog_reset_n     (prog_reset_n),
    .cfg              (cfg_if),
    .chany_bottom_in  (chany_bottom_in),
    .chanx_left_in    (chanx_left_in),
    .bottom_mux_in    (bottom_mux_in),
    .left_mux_in      (left_mux_in),
    .chany_bottom_out (chany_bottom_out),
    .chanx_left_out   (chanx_left_out)
  );

  always #5 prog_clk = ~prog_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: plain integers, shadow treated as a CFG_BITS-wide shift value.
  int m_shadow;
  int m_active;
  int m_count;
  bit m_valid;
  bit m_ovf;

  task automatic model_reset();
    m_shadow = 0;
    m_active = 0;
    m_count  = 0;
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit head, input bit commit);
    if (commit) begin
      m_active = m_shadow;
      m_valid  = 1'b1;
      m_ovf    = 1'b0;
      m_count  = en ? 1 : 0;
    end else if (en) begin
      if (m_count == CFG_BITS) m_ovf = 1'b1;
      else m_count = m_count + 1;
    end
    if (en) m_shadow = ((m_shadow * 2) + int'(head)) % (1 << CFG_BITS);
  endtask

  function automatic logic [CHAN_W-1:0] exp_out(input bit bottom);
    logic [CHAN_W-1:0]     r;
    logic [M*MUX_SIZE-1:0] ins;
    int                    sel;
    int                    j;
    ins = bottom ? bottom_mux_in : left_mux_in;
    for (int k = 0; k < CHAN_W; k++) begin
      if (k < M) begin
        j      = bottom ? k : M + k;
        sel    = (m_active >> (j * SEL_W)) % (1 << SEL_W);
        r[k]   = (m_valid && sel < MUX_SIZE) ? ins[k*MUX_SIZE + sel] : 1'b0;
      end else begin
        r[k] = bottom ? chanx_left_in[k] : chany_bottom_in[k];
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_tail"},  32'(cfg_if.ccff_tail),    32'((m_shadow >> (CFG_BITS - 1)) & 1));
    chk({tag, "_valid"}, 32'(cfg_if.cfg_valid),    32'(m_valid));
    chk({tag, "_done"},  32'(cfg_if.cfg_done),     32'(m_count == CFG_BITS));
    chk({tag, "_ovf"},   32'(cfg_if.cfg_overflow), 32'(m_ovf));
    chk({tag, "_bot"},   32'(chany_bottom_out),    32'(exp_out(1'b1)));
    chk({tag, "_left"},  32'(chanx_left_out),      32'(exp_out(1'b0)));
  endtask

  task automatic step(input bit en, input bit head, input bit commit, input string tag);
    cfg_if.ccff_en    = en;
    cfg_if.ccff_head  = head;
    cfg_if.cfg_commit = commit;
    model_edge(en, head, commit);
    @(posedge prog_clk);
    #1;
    cfg_if.ccff_en    = 1'b0;
    cfg_if.cfg_commit = 1'b0;
    check_all(tag);
  endtask

  task automatic load_byte(input logic [7:0] v, input string tag);
    for (int i = 7; i >= 0; i--) step(1'b1, v[i], 1'b0, tag);
  endtask

  logic [7:0] tail_exp;
  logic [7:0] rnd_byte;

  initial begin
    prog_reset_n      = 1'b0;
    cfg_if.ccff_head  = 1'b0;
    cfg_if.ccff_en    = 1'b0;
    cfg_if.cfg_commit = 1'b0;
    chany_bottom_in   = '0;
    chanx_left_in     = '0;
    bottom_mux_in     = '0;
    left_mux_in       = '0;
    model_reset();
    repeat (2) @(posedge prog_clk);
    #1;
    check_all("por");
    @(negedge prog_clk);
    prog_reset_n = 1'b1;

    // Reset asserted mid-cycle with all channel inputs high
    for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0, "pre_rst");
    chany_bottom_in = 9'h1FF;
    chanx_left_in   = 9'h1FF;
    prog_reset_n    = 1'b0;
    #2;
    model_reset();
    chk("t1_bot",   32'(chany_bottom_out),    32'h1FC);
    chk("t1_left",  32'(chanx_left_out),      32'h1FC);
    chk("t1_tail",  32'(cfg_if.ccff_tail),    32'h0);
    chk("t1_valid", 32'(cfg_if.cfg_valid),    32'h0);
    chk("t1_done",  32'(cfg_if.cfg_done),     32'h0);
    chk("t1_ovf",   32'(cfg_if.cfg_overflow), 32'h0);
    check_all("t1");
    @(negedge prog_clk);
    prog_reset_n = 1'b1;

    // Load 8'hB4 and commit
    bottom_mux_in = 8'b0010_0001;
    left_mux_in   = 8'b0100_1000;
    load_byte(8'hB4, "t2_load");
    chk("t2_done_pre", 32'(cfg_if.cfg_done), 32'h1);
    step(1'b0, 1'b0, 1'b1, "t2_commit");
    chk("t2_bot_mux",  32'(chany_bottom_out[1:0]), 32'h3);
    chk("t2_left_mux", 32'(chanx_left_out[1:0]),   32'h3);
    chk("t2_valid",    32'(cfg_if.cfg_valid),      32'h1);

    // Overflow on the ninth shift, sticky until commit
    for (int i = 0; i < 8; i++) step(1'b1, 1'($urandom), 1'b0, "t3_load");
    chk("t3_done", 32'(cfg_if.cfg_done),     32'h1);
    chk("t3_ovf0", 32'(cfg_if.cfg_overflow), 32'h0);
    step(1'b1, 1'($urandom), 1'b0, "t3_ninth");
    chk("t3_ovf1", 32'(cfg_if.cfg_overflow), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, "t3_idle");
      chk("t3_ovf_sticky", 32'(cfg_if.cfg_overflow), 32'h1);
    end
    step(1'b0, 1'b0, 1'b1, "t3_commit");
    chk("t3_ovf_clr", 32'(cfg_if.cfg_overflow), 32'h0);
    chk("t3_valid",   32'(cfg_if.cfg_valid),    32'h1);

    // Commit coinciding with a shift
    load_byte(8'hB4, "t4_load");
    step(1'b1, 1'b1, 1'b1, "t4_both");
    chk("t4_active", 32'(dut.u_chain.active_q), 32'hB4);
    chk("t4_shadow", 32'(dut.u_chain.shadow_q), 32'h69);
    chk("t4_count",  32'(dut.u_chain.count_q),  32'h1);
    chk("t4_done",   32'(cfg_if.cfg_done),      32'h0);

    // Tail readback of a loaded byte
    load_byte(8'hB4, "t6_load");
    tail_exp = 8'b1011_0100;
    for (int i = 0; i < 8; i++) begin
      chk("t6_tail", 32'(cfg_if.ccff_tail), 32'(tail_exp[7-i]));
      step(1'b1, 1'b0, 1'b0, "t6_shift");
    end
    chk("t6_shadow", 32'(dut.u_chain.shadow_q), 32'h0);
    chk("t6_active", 32'(dut.u_chain.active_q), 32'hB4);

    // Reset in the middle of a load
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, "t5_part");
    prog_reset_n = 1'b0;
    #2;
    model_reset();
    chk("t5_shadow", 32'(dut.u_chain.shadow_q), 32'h0);
    chk("t5_active", 32'(dut.u_chain.active_q), 32'h0);
    chk("t5_count",  32'(dut.u_chain.count_q),  32'h0);
    chk("t5_muxb",   32'(chany_bottom_out[M-1:0]), 32'h0);
    chk("t5_muxl",   32'(chanx_left_out[M-1:0]),   32'h0);
    check_all("t5_rst");
    @(negedge prog_clk);
    prog_reset_n = 1'b1;
    rnd_byte = 8'($urandom);
    load_byte(rnd_byte, "t5_reload");
    chk("t5_done", 32'(cfg_if.cfg_done), 32'h1);
    step(1'b0, 1'b0, 1'b1, "t5_commit");

    // Randomised traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      chany_bottom_in = 9'($urandom);
      chanx_left_in   = 9'($urandom);
      bottom_mux_in   = 8'($urandom);
      left_mux_in     = 8'($urandom);
      step(($urandom % 4) != 0, 1'($urandom), ($urandom % 16) == 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
